fetch_unit: RTL
===============

# fetch_unit

Instruction fetch front-end for the 32-bit CPU. Drives byte addresses into the code memory, absorbs its fixed one-cycle synchronous read latency, and presents fetched instructions with their PC to decode over a valid/ready handshake. Handles branch redirects by flushing buffered and in-flight fetches, and stalls issue when decode back-pressures.

## Interface
- `RESET_VEC`, default `32'h0000_0000`: byte address fetched first after reset; word-aligned.
- `DEPTH`, default `2`: output buffer entries; power of two and ≥2.
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: asynchronous, active-low (`reset`=0 resets).
- `imem_addr` out 32: byte address to code memory; bits [1:0] always 0.
- `imem_inst` in 32: code memory read data; valid the cycle after the address was presented.
- `br_valid` in 1: redirect request, single-cycle pulse.
- `br_target` in 32: redirect byte address; bits [1:0] ignored (treated as 0).
- `out_valid` out 1: buffer head holds an instruction.
- `out_ready` in 1: decode accepts head this cycle.
- `out_inst` out 32: head instruction.
- `out_pc` out 32: byte address of `out_inst`.

## Operation
- State: `fetch_pc` (next address to issue), `inflight` (1 bit: response due next cycle), `req_pc` (PC of in-flight request), FIFO of {inst, pc} with `count`.
- `imem_addr` = `fetch_pc` at all times; the memory reads every cycle, and only responses with `inflight`=1 are captured.
- `pop` = `out_valid` & `out_ready`.
- Issue when `count + inflight - pop < DEPTH` and no `br_valid`: `inflight`<=1, `req_pc`<=`fetch_pc`, `fetch_pc`<=`fetch_pc`+4. Otherwise `inflight`<=0 and `fetch_pc` holds.
- Capture: if `inflight`=1 and no `br_valid`, push {`imem_inst`, `req_pc`}.
- Push and pop in the same cycle: `count` unchanged. The issue rule guarantees a push never finds the FIFO full.
- Redirect (`br_valid`=1), which has priority over everything:
  - Clear the FIFO (`count`<=0).
  - `inflight`<=0, so the response arriving next cycle is discarded.
  - Drop any capture this cycle.
  - `fetch_pc`<={`br_target`[31:2], 2'b00}.
  - A handshake completing in the redirect cycle still counts as consumed.
- Back-to-back redirects: each flushes; the last target wins.
- `fetch_pc` wraps modulo 2^32 with no fault.
- Reset values:
  - `fetch_pc`=`RESET_VEC` (so `imem_addr`=`RESET_VEC`).
  - `inflight`=0, `count`=0, `out_valid`=0.
  - `out_inst`=0, `out_pc`=0 when empty.
- Reset mid-operation discards all state immediately (asynchronous).

## Timing
- Reset released before edge E0: cycle 0 presents `RESET_VEC`. Cycle 1: `imem_inst` valid, captured at the end of cycle 1. Cycle 2: `out_valid`=1 with `out_pc`=`RESET_VEC`.
- Steady state with `out_ready`=1: one instruction per cycle, PCs +4 consecutive, `count` settles at 1.
- `br_valid` in cycle t:
  - `imem_addr`=target in cycle t+1.
  - `out_valid`=0 in cycles t+1 and t+2.
  - Target instruction at head in t+3.
- `out_ready`=0 with `DEPTH`=2: at most 2 buffered. `fetch_pc` freezes at (last buffered PC)+4, and nothing is lost or duplicated on release.
- Outputs `out_*` are registered FIFO head with no combinational path from `imem_inst`. `imem_addr` is registered.

## Structure
- Shared package `cpu_pkg`: `INST_W`=32, `ADDR_W`=32, `RESET_VEC` default, `PC_INC`=4.
- Sub-module `fetch_fifo`: synchronous FIFO with parameters `WIDTH`, `DEPTH`, ports `push`/`pop`/`flush`, and `count`. Flush has priority over push and pop.
- The issue/capture/redirect control stays in `fetch_unit`.

## Test plan
- Reset, then `out_ready`=1; code memory word k = `32'hE000_0000`+k. Required: first `out_valid` in cycle 2 with inst `E0000000`/pc `0`, then pc 4, 8, 12 on consecutive cycles.
- Hold `out_ready`=0 for 5 cycles after the first valid, then release. Required: `count` ≤2, `imem_addr` frozen, and the PC sequence continues 0, 4, 8, … with no gap or repeat.
- `br_valid` with `br_target`=`32'h0000_0103` while streaming. Required: `imem_addr`=`0x100` the next cycle, `out_valid`=0 for 2 cycles, then pc `0x100`, `0x104`; no stale PCs appear.
- `br_valid` in two consecutive cycles, targets `0x40` then `0x80`. Required: the first instruction delivered afterwards has pc `0x80`.
- Redirect coinciding with a pop and a full FIFO. Required: the popped entry is consumed once, the FIFO is empty the next cycle, and there is no overflow.
- Assert `reset`=0 asynchronously mid-stream. Required: `out_valid`=0 and `imem_addr`=`RESET_VEC` immediately, without waiting for a clock edge; the stream restarts from `RESET_VEC` after release.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU constants and types used by the fetch front-end.
package cpu_pkg;

  localparam int INST_W = 32;
  localparam int ADDR_W = 32;
  localparam logic [ADDR_W-1:0] RESET_VEC = 32'h0000_0000;
  localparam logic [ADDR_W-1:0] PC_INC = 32'd4;

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [ADDR_W-1:0] pc;
  } fetch_entry_t;

  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
    return addr & ~ADDR_W'(3);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO holding fetched {inst, pc} entries; flush wins over push/pop.
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0]    rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0]    count_reg, count_next;
  logic             push_eff, pop_eff;

  assign valid    = (count_reg != '0);
  assign count    = count_reg;
  assign pop_eff  = pop && valid && !flush;
  assign push_eff = push && !flush;
  // Head is gated so an empty buffer presents zeros rather than stale data.
  assign dout     = valid ? mem[rd_ptr_reg] : '0;

  always_ff @(posedge clk) begin
    if (push_eff) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (flush) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
    end else begin
      if (push_eff) wr_ptr_next = wr_ptr_reg + AW'(1);
      if (pop_eff)  rd_ptr_next = rd_ptr_reg + AW'(1);
      case ({push_eff, pop_eff})
        2'b10:   count_next = count_reg + CW'(1);
        2'b01:   count_next = count_reg - CW'(1);
        default: count_next = count_reg;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front-end: issues word addresses, captures one-cycle-latency
// responses into a small buffer, and flushes everything on a branch redirect.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_VEC = cpu_pkg::RESET_VEC,
  parameter int          DEPTH     = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_inst,
  input  logic        br_valid,
  input  logic [31:0] br_target,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [ADDR_W-1:0] fetch_pc_reg, fetch_pc_next;
  logic [ADDR_W-1:0] req_pc_reg, req_pc_next;
  logic              inflight_reg, inflight_next;
  logic [CW-1:0]     fifo_count;
  logic [CW:0]       occupancy;
  logic              pop, issue, capture;
  fetch_entry_t      push_entry, head_entry;

  assign imem_addr = fetch_pc_reg;
  assign pop       = out_valid && out_ready;

  // Entries that will be resident after this cycle, counting the response in flight.
  assign occupancy = {1'b0, fifo_count} + (CW+1)'(inflight_reg) - (CW+1)'(pop);
  assign issue     = !br_valid && (occupancy < (CW+1)'(DEPTH));
  assign capture   = inflight_reg && !br_valid;

  always_comb begin
    fetch_pc_next = fetch_pc_reg;
    req_pc_next   = req_pc_reg;
    inflight_next = 1'b0;
    if (br_valid) begin
      fetch_pc_next = word_align(br_target);
    end else if (issue) begin
      inflight_next = 1'b1;
      req_pc_next   = fetch_pc_reg;
      fetch_pc_next = fetch_pc_reg + PC_INC;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_reg <= RESET_VEC;
      req_pc_reg   <= '0;
      inflight_reg <= 1'b0;
    end else begin
      fetch_pc_reg <= fetch_pc_next;
      req_pc_reg   <= req_pc_next;
      inflight_reg <= inflight_next;
    end
  end

  assign push_entry.inst = imem_inst;
  assign push_entry.pc   = req_pc_reg;

  fetch_fifo #(
    .WIDTH($bits(fetch_entry_t)),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (capture),
    .pop   (pop),
    .flush (br_valid),
    .din   (push_entry),
    .dout  (head_entry),
    .valid (out_valid),
    .count (fifo_count)
  );

  assign out_inst = head_entry.inst;
  assign out_pc   = head_entry.pc;

endmodule
